// File: rtl/alu_sequencer_if.sv
// Request, ALU drive and response bundle for alu_sequencer.
// slave: the sequencer side; master: the requester / ALU / response-sink side.
interface alu_sequencer_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              req_carry;

  logic [DATA_W-1:0] alu_in_1;
  logic [DATA_W-1:0] alu_in_2;
  logic [OP_W-1:0]   alu_select;
  logic              alu_carry_in;
  logic              alu_enable;
  logic [DATA_W-1:0] alu_data;
  logic              alu_carry;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;
  logic              rsp_err;

  logic              flag_carry;
  logic              flag_zero;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_carry,
    input  alu_data, alu_carry, alu_zero,
    input  rsp_ready,
    output req_ready,
    output alu_in_1, alu_in_2, alu_select, alu_carry_in, alu_enable,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
    output flag_carry, flag_zero
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_carry,
    output alu_data, alu_carry, alu_zero,
    output rsp_ready,
    input  req_ready,
    input  alu_in_1, alu_in_2, alu_select, alu_carry_in, alu_enable,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
    input  flag_carry, flag_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request: IDLE -> SETUP -> EXEC (SETTLE_CYCLES) -> RESP.
// Optional feature: define ALU_CARRY_CHAIN_EN to feed op 0 carry-in from flag_carry.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c;
  logic             capture_c;
  logic             carry_src_c;

  // Next-state and handshake qualifiers.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept_c = 1'b1;
          state_d  = bus.req_op[3] ? RESP : SETUP;
        end
      end
      SETUP: state_d = EXEC;
      EXEC: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          capture_c = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Carry-in source for add: chained from the last result or taken from the request.
`ifdef ALU_CARRY_CHAIN_EN
  assign carry_src_c = bus.flag_carry;
`else
  assign carry_src_c = bus.req_carry;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // EXEC dwell counter; cleared outside EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt_q <= '0;
    else if (state_q == EXEC) cnt_q <= cnt_q + CNT_W'(1);
    else                      cnt_q <= '0;
  end

  // Registered handshake and ALU enable, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.alu_enable <= 1'b0;
    end else begin
      bus.req_ready  <= (state_d == IDLE);
      bus.rsp_valid  <= (state_d == RESP);
      bus.alu_enable <= (state_d == EXEC);
    end
  end

  // ALU operand latches, loaded on acceptance of a valid op and held through EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.alu_in_1     <= '0;
      bus.alu_in_2     <= '0;
      bus.alu_select   <= '0;
      bus.alu_carry_in <= 1'b0;
    end else if (accept_c && !bus.req_op[3]) begin
      bus.alu_in_1     <= bus.req_a;
      bus.alu_in_2     <= (bus.req_op >= 4'd5) ? '0 : bus.req_b;
      bus.alu_select   <= bus.req_op;
      bus.alu_carry_in <= (bus.req_op == 4'd0) ? carry_src_c : 1'b0;
    end
  end

  // Response payload and persistent flags; error responses leave flags untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.flag_carry <= 1'b0;
      bus.flag_zero  <= 1'b0;
    end else if (accept_c && bus.req_op[3]) begin
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b1;
    end else if (capture_c) begin
      bus.rsp_result <= bus.alu_data;
      bus.rsp_carry  <= bus.alu_carry;
      bus.rsp_zero   <= bus.alu_zero;
      bus.rsp_err    <= 1'b0;
      bus.flag_carry <= bus.alu_carry;
      bus.flag_zero  <= bus.alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, response scoreboard, reset and stall cases.
module tb_alu_sequencer;

  localparam int unsigned SETTLE = 2;
  localparam int          TCLK   = 10;

  typedef struct {
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t sb[$];
  logic m_fc = 1'b0;
  logic m_fz = 1'b0;
  logic [16:0] alu_r;
  time  t0, t1;

  always #(TCLK/2) clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference ALU: {carry, result}; sub carry is borrow, inc/dec carry is wrap.
  function automatic logic [16:0] alu_f(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic cin);
    logic [16:0] r;
    case (op)
      4'd0: r = {1'b0, a} + {1'b0, b} + 17'(cin);
      4'd1: r = {a < b, 16'(a - b)};
      4'd2: r = {1'b0, a & b};
      4'd3: r = {1'b0, a | b};
      4'd4: r = {1'b0, a ^ b};
      4'd5: r = {1'b0, ~a};
      4'd6: r = {1'b0, a} + 17'd1;
      4'd7: r = {a == 16'd0, 16'(a - 16'd1)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Behavioural ALU: garbage while disabled so mistimed captures show up.
  always_comb begin
    alu_r = alu_f(bus.alu_select, bus.alu_in_1, bus.alu_in_2, bus.alu_carry_in);
    if (bus.alu_enable) begin
      bus.alu_data  = alu_r[15:0];
      bus.alu_carry = alu_r[16];
      bus.alu_zero  = (alu_r[15:0] == 16'd0);
    end else begin
      bus.alu_data  = 16'hDEAD;
      bus.alu_carry = 1'b1;
      bus.alu_zero  = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, follow it through the FSM, then compare against the scoreboard.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input int stall, output time t_acc);
    rsp_t        e;
    rsp_t        got;
    logic [16:0] r;
    logic        ecin;
    logic [15:0] eb;
    int          idx;
    int          guard;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_carry = cin;
    bus.rsp_ready = (stall == 0);
    @(posedge clk);
    t_acc = $time;
`ifdef ALU_CARRY_CHAIN_EN
    ecin = (op == 4'd0) ? m_fc : 1'b0;
`else
    ecin = (op == 4'd0) ? cin : 1'b0;
`endif
    eb = (op >= 4'd5) ? 16'd0 : b;
    if (op[3]) begin
      e = '{result: 16'd0, carry: 1'b0, zero: 1'b0, err: 1'b1};
    end else begin
      r = alu_f(op, a, b, ecin);
      e = '{result: r[15:0], carry: r[16], zero: (r[15:0] == 16'd0), err: 1'b0};
      m_fc = e.carry;
      m_fz = e.zero;
    end
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    idx = 1;
    while (!bus.rsp_valid && idx < 40) begin
      check("busy_req_ready", 32'(bus.req_ready), 32'd0);
      check("alu_enable", 32'(bus.alu_enable), (idx >= 2) ? 32'd1 : 32'd0);
      check("alu_in_1", 32'(bus.alu_in_1), 32'(a));
      check("alu_in_2", 32'(bus.alu_in_2), 32'(eb));
      check("alu_select", 32'(bus.alu_select), 32'(op));
      check("alu_carry_in", 32'(bus.alu_carry_in), 32'(ecin));
      @(negedge clk);
      idx++;
    end
    check("latency", 32'(idx), op[3] ? 32'd1 : 32'(2 + SETTLE));
    check("resp_enable_low", 32'(bus.alu_enable), 32'd0);
    for (int s = 0; s < stall; s++) begin
      bus.req_valid = 1'b1;
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_result", 32'(bus.rsp_result), 32'(e.result));
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e   = sb.pop_front();
      got = '{result: bus.rsp_result, carry: bus.rsp_carry, zero: bus.rsp_zero, err: bus.rsp_err};
      check("rsp_result", 32'(got.result), 32'(e.result));
      check("rsp_carry", 32'(got.carry), 32'(e.carry));
      check("rsp_zero", 32'(got.zero), 32'(e.zero));
      check("rsp_err", 32'(got.err), 32'(e.err));
      check("flag_carry", 32'(bus.flag_carry), 32'(m_fc));
      check("flag_zero", 32'(bus.flag_zero), 32'(m_fz));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time ta;
    logic [16:0] chain_r;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_carry = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
    check("rst_alu_in_1", 32'(bus.alu_in_1), 32'd0);
    check("rst_alu_in_2", 32'(bus.alu_in_2), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_flags", 32'({bus.flag_carry, bus.flag_zero}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Wrapping add sets carry and zero.
    run_op(4'd0, 16'hFFFF, 16'h0001, 1'b0, 0, ta);
    check("add_flag_carry_set", 32'(bus.flag_carry), 32'd1);
    // Invalid op: error response, flags preserved.
    run_op(4'd9, 16'h1234, 16'h0000, 1'b0, 0, ta);
    // AND held under a 10-cycle response stall.
    run_op(4'd2, 16'hF0F0, 16'h0FF0, 1'b0, 10, ta);

    // Carry chain pair: second add result depends on build.
    run_op(4'd0, 16'hFFFF, 16'h0001, 1'b0, 0, ta);
    run_op(4'd0, 16'h0000, 16'h0000, 1'b0, 0, ta);
`ifdef ALU_CARRY_CHAIN_EN
    chain_r = 17'h00001;
`else
    chain_r = 17'h00000;
`endif
    check("chain_result", 32'(bus.rsp_result), 32'(chain_r[15:0]));

    // Back-to-back ops with rsp_ready high; period between accepts.
    run_op(4'd1, 16'h0005, 16'h0007, 1'b0, 0, t0);
    run_op(4'd3, 16'hA000, 16'h0055, 1'b0, 0, t1);
    check("b2b_period", 32'(int'(t1 - t0)), 32'((3 + SETTLE) * TCLK));
    run_op(4'd4, 16'hFF00, 16'h0FF0, 1'b0, 0, ta);
    run_op(4'd5, 16'h00FF, 16'hFFFF, 1'b1, 0, ta);
    run_op(4'd6, 16'hFFFF, 16'h1234, 1'b1, 0, ta);
    run_op(4'd7, 16'h0000, 16'h5678, 1'b0, 0, ta);
    run_op(4'd0, 16'h0001, 16'h0002, 1'b1, 0, ta);

    // Reset mid-EXEC: make flags non-zero first so the clear is observable.
    run_op(4'd0, 16'hFFFF, 16'h0001, 1'b0, 0, ta);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd6;
    bus.req_a     = 16'h0010;
    bus.req_b     = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_exec_en", 32'(bus.alu_enable), 32'd1);
    reset = 1'b1;
    #1;
    m_fc = 1'b0;
    m_fz = 1'b0;
    check("midrst_alu_enable", 32'(bus.alu_enable), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_flags", 32'({bus.flag_carry, bus.flag_zero}), 32'({m_fc, m_fz}));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end

    // Recovery after reset.
    run_op(4'd6, 16'h0010, 16'h0000, 1'b0, 0, ta);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
